button_autorepeat: RTL and testbench
====================================

Name: button_autorepeat

Overview:
- Sits between the button debouncer and the digit counter.
- Converts a clean, debounced button level into count-step pulses: one pulse on press, then after a hold delay, periodic auto-repeat pulses for as long as the button is held.
- Also flags a short tap and a long press.
- One instance is built per button; the counter's button-event input takes `step`.

Parameters:
- CLK_PER, 10, clock period in ns. TICK_CYCLES = 1_000_000/CLK_PER (integer division) clock cycles make one ms tick.
- HOLD_MS, 500, ms from press to the first repeat step. Must be ≥1 (elaboration error otherwise).
- REPEAT_MS, 100, ms between repeat steps. Must be ≥1.
- LONG_MS, 2000, ms of continuous hold before `long_press` asserts. Must be ≥1.
- ENABLE_REPEAT, 1, 0 disables auto-repeat (the block stays in HOLD until release).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- button_level  in  1  debounced button level, 1 = pressed, synchronous to clk
- step  out  1  one-cycle count pulse
- tap  out  1  one-cycle pulse: released before the first repeat step
- long_press  out  1  level: held ≥ LONG_MS, cleared on release
- repeating  out  1  level: in the auto-repeat phase

Behaviour:
- Reset (async, active-high):
  - State = IDLE.
  - All outputs 0; all counters 0.
  - btn_q = 1, so a button held through reset is ignored until it is released and pressed again.
- btn_q is button_level registered once.
  - rise = button_level & ~btn_q
  - fall = ~button_level & btn_q
- Outputs are registered. Every pulse is high for exactly one cycle, in the cycle after the edge that detected its event.
- Prescaler: counts 0..TICK_CYCLES-1 while the state is not IDLE. Held at 0 in IDLE and cleared on the press edge. `tick` is asserted when prescaler = TICK_CYCLES-1.
- ms_cnt: phase timer.
  - Increments on tick; cleared on each phase change and on each repeat step.
  - Width = clog2(max(HOLD_MS, REPEAT_MS) + 1).
- hold_cnt: total hold time.
  - Increments on tick and saturates at LONG_MS.
  - Width = clog2(LONG_MS + 1).
  - Cleared in IDLE.
- State IDLE:
  - On rise: step = 1, go to HOLD, clear the prescaler and both counters.
- State HOLD:
  - On fall: tap = 1, go to IDLE.
  - Else, on a tick that makes ms_cnt = HOLD_MS with ENABLE_REPEAT = 1: step = 1, repeating = 1, ms_cnt = 0, go to REPEAT.
  - With ENABLE_REPEAT = 0: remain in HOLD; no further steps.
- State REPEAT:
  - On fall: repeating = 0, go to IDLE; no tap.
  - Else, on a tick that makes ms_cnt = REPEAT_MS: step = 1, ms_cnt = 0.
- long_press:
  - Set on the tick where hold_cnt reaches LONG_MS, in HOLD or REPEAT.
  - Cleared on the edge that detects fall.
- Step spacing (press step to first repeat step to subsequent steps):
  - Press step to first repeat step is exactly HOLD_MS·TICK_CYCLES cycles.
  - Subsequent steps are exactly REPEAT_MS·TICK_CYCLES cycles apart.
- Simultaneous events:
  - fall on the same edge as a scheduled step or long_press set: fall wins. No step, long_press stays 0 or clears, state goes to IDLE.
  - HOLD-state fall coinciding with HOLD expiry: tap = 1, no step.
- rise while not IDLE is impossible, because btn_q tracks the level. No extra handling is needed.
- Reset mid-operation:
  - Immediate return to the reset values.
  - A pulse in flight is dropped.
  - No step after deassert while the button is still held.

Test Plan:
All scenarios use CLK_PER=250000 (4 cycles/ms), HOLD_MS=5, REPEAT_MS=2, LONG_MS=12.
1. Reset with button_level=0, then idle 100 cycles -> step, tap, long_press and repeating all 0 throughout.
2. Press for 12 cycles, then release -> exactly one step, 1 cycle after the press edge; one tap, 1 cycle after the release edge; repeating never asserts.
3. Hold for 40 cycles -> steps at relative cycles 0, 20, 28, 36 (4 total). repeating rises with the step at 20 and falls 1 cycle after release; tap = 0.
4. Hold for 52 cycles -> long_press rises 48 cycles after the first step, stays high until release, and drops 1 cycle after the release edge.
5. Assert reset at cycle 25 of a hold, deassert while still held -> outputs 0 immediately, no step while held. Release then re-press -> step 1 cycle after the re-press edge.
6. Release on the exact edge where the repeat step at cycle 28 would be generated -> no step at 28, tap = 0, state IDLE. The next press yields a normal step.

Source files
------------

// File: rtl/button_autorepeat.sv
// -----------------------------------------------------------------------------
// button_autorepeat
//
// Turns a clean, debounced button level into count-step pulses for the digit
// counter. A press gives one step straight away. If the button is still held
// after HOLD_MS, the block enters an auto-repeat phase and gives one step
// every REPEAT_MS until release. It also reports a short tap (released before
// the first repeat step) and a long press (held for at least LONG_MS).
//
// Build one instance per button and feed `step` to the counter's button-event
// input.
//
// Parameters:
//   CLK_PER       clock period in ns; TICK_CYCLES = 1_000_000 / CLK_PER cycles
//                 make one millisecond tick
//   HOLD_MS       ms from the press step to the first repeat step (>= 1)
//   REPEAT_MS     ms between repeat steps (>= 1)
//   LONG_MS       ms of continuous hold before long_press asserts (>= 1)
//   ENABLE_REPEAT 0 = never auto-repeat; the block stays in HOLD until release
//
// Ports:
//   clk           system clock
//   reset         asynchronous, active-high reset
//   button_level  debounced button level, 1 = pressed, synchronous to clk
//   step          one-cycle count pulse
//   tap           one-cycle pulse: released before the first repeat step
//   long_press    level: held >= LONG_MS, cleared on release
//   repeating     level: in the auto-repeat phase
//   dbg_state     current FSM state (0 = IDLE, 1 = HOLD, 2 = REPEAT)
//
// Timing: every output is registered. A pulse is high for exactly one cycle,
// the cycle after the clock edge that saw its event.
// -----------------------------------------------------------------------------
module button_autorepeat #(
  parameter int CLK_PER       = 10,
  parameter int HOLD_MS       = 500,
  parameter int REPEAT_MS     = 100,
  parameter int LONG_MS       = 2000,
  parameter int ENABLE_REPEAT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       button_level,
  output logic       step,
  output logic       tap,
  output logic       long_press,
  output logic       repeating,
  output logic [1:0] dbg_state
);

  // ---------------------------------------------------------------------------
  // Derived sizes and constants
  // ---------------------------------------------------------------------------
  localparam int TICK_CYCLES = 1_000_000 / CLK_PER;

  // The prescaler needs at least one bit, even when one cycle is one tick.
  localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

  // The phase timer is shared by HOLD and REPEAT, so it is sized for the
  // longer of the two phases.
  localparam int MS_MAX = (HOLD_MS > REPEAT_MS) ? HOLD_MS : REPEAT_MS;
  localparam int MW     = (MS_MAX > 0) ? $clog2(MS_MAX + 1) : 1;
  localparam int HW     = (LONG_MS > 0) ? $clog2(LONG_MS + 1) : 1;

  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_CYCLES - 1);
  localparam logic [MW-1:0] HOLD_LAST = MW'(HOLD_MS - 1);
  localparam logic [MW-1:0] HOLD_VAL  = MW'(HOLD_MS);
  localparam logic [MW-1:0] REP_LAST  = MW'(REPEAT_MS - 1);
  localparam logic [HW-1:0] LONG_LAST = HW'(LONG_MS - 1);
  localparam logic [HW-1:0] LONG_VAL  = HW'(LONG_MS);

  localparam bit REPEAT_ON = (ENABLE_REPEAT != 0);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ---------------------------------------------------------------------------
  if (HOLD_MS < 1) begin : g_bad_hold
    $error("button_autorepeat: HOLD_MS must be >= 1");
  end
  if (REPEAT_MS < 1) begin : g_bad_repeat
    $error("button_autorepeat: REPEAT_MS must be >= 1");
  end
  if (LONG_MS < 1) begin : g_bad_long
    $error("button_autorepeat: LONG_MS must be >= 1");
  end
  if (TICK_CYCLES < 1) begin : g_bad_clk
    $error("button_autorepeat: CLK_PER must be <= 1_000_000");
  end

  // ---------------------------------------------------------------------------
  // State and registers
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } state_t;

  state_t        r_state;
  logic          r_btn_q;     // button_level delayed by one cycle
  logic [PW-1:0] r_presc;     // cycles within the current ms
  logic [MW-1:0] r_ms_cnt;    // ms elapsed in the current phase
  logic [HW-1:0] r_hold_cnt;  // ms held in total, saturating at LONG_MS

  logic          r_step;
  logic          r_tap;
  logic          r_long;
  logic          r_repeating;

  // ---------------------------------------------------------------------------
  // Edge detection and the ms tick
  // ---------------------------------------------------------------------------
  // After reset r_btn_q is 1. A button held through reset therefore gives no
  // rise until it has been released and pressed again.
  logic w_rise;
  logic w_fall;
  logic w_tick;

  assign w_rise = button_level & ~r_btn_q;
  assign w_fall = ~button_level & r_btn_q;
  assign w_tick = (r_presc == TICK_LAST);

  // ---------------------------------------------------------------------------
  // FSM with registered outputs
  //
  // Priority inside HOLD and REPEAT: a fall beats everything else on the same
  // edge. It suppresses a scheduled step, suppresses or clears long_press, and
  // returns to IDLE.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_btn_q     <= 1'b1;
      r_presc     <= '0;
      r_ms_cnt    <= '0;
      r_hold_cnt  <= '0;
      r_step      <= 1'b0;
      r_tap       <= 1'b0;
      r_long      <= 1'b0;
      r_repeating <= 1'b0;
    end else begin
      r_btn_q <= button_level;

      // Pulse outputs default low, so each pulse lasts one cycle.
      r_step <= 1'b0;
      r_tap  <= 1'b0;

      case (r_state)
        // ---------------------------------------------------------------------
        ST_IDLE: begin
          // All timers stay at zero while idle. A press then starts a phase
          // that is exactly aligned to the press edge.
          r_presc     <= '0;
          r_ms_cnt    <= '0;
          r_hold_cnt  <= '0;
          r_long      <= 1'b0;
          r_repeating <= 1'b0;
          if (w_rise) begin
            r_step  <= 1'b1;
            r_state <= ST_HOLD;
          end
        end

        // ---------------------------------------------------------------------
        ST_HOLD: begin
          if (w_fall) begin
            // Released before the first repeat step: a tap. This includes a
            // release on the same edge as the HOLD expiry.
            r_tap       <= 1'b1;
            r_state     <= ST_IDLE;
            r_presc     <= '0;
            r_ms_cnt    <= '0;
            r_hold_cnt  <= '0;
            r_long      <= 1'b0;
            r_repeating <= 1'b0;
          end else begin
            r_presc <= w_tick ? '0 : r_presc + PW'(1);
            if (w_tick) begin
              // long_press sets once, on the tick that brings hold_cnt to
              // LONG_MS. After that, hold_cnt saturates.
              if (r_hold_cnt == LONG_LAST) begin
                r_long <= 1'b1;
              end
              if (r_hold_cnt != LONG_VAL) begin
                r_hold_cnt <= r_hold_cnt + HW'(1);
              end

              if (REPEAT_ON && (r_ms_cnt == HOLD_LAST)) begin
                // This tick brings ms_cnt to HOLD_MS: first repeat step.
                r_step      <= 1'b1;
                r_repeating <= 1'b1;
                r_ms_cnt    <= '0;
                r_state     <= ST_REPEAT;
              end else if (r_ms_cnt != HOLD_VAL) begin
                // With repeat disabled, the phase timer parks at HOLD_MS
                // rather than wrapping.
                r_ms_cnt <= r_ms_cnt + MW'(1);
              end
            end
          end
        end

        // ---------------------------------------------------------------------
        ST_REPEAT: begin
          if (w_fall) begin
            // Release after repeating has started: no tap.
            r_state     <= ST_IDLE;
            r_presc     <= '0;
            r_ms_cnt    <= '0;
            r_hold_cnt  <= '0;
            r_long      <= 1'b0;
            r_repeating <= 1'b0;
          end else begin
            r_presc <= w_tick ? '0 : r_presc + PW'(1);
            if (w_tick) begin
              if (r_hold_cnt == LONG_LAST) begin
                r_long <= 1'b1;
              end
              if (r_hold_cnt != LONG_VAL) begin
                r_hold_cnt <= r_hold_cnt + HW'(1);
              end

              if (r_ms_cnt == REP_LAST) begin
                // This tick brings ms_cnt to REPEAT_MS: the next repeat step.
                r_step   <= 1'b1;
                r_ms_cnt <= '0;
              end else begin
                r_ms_cnt <= r_ms_cnt + MW'(1);
              end
            end
          end
        end

        // ---------------------------------------------------------------------
        default: begin
          r_state     <= ST_IDLE;
          r_presc     <= '0;
          r_ms_cnt    <= '0;
          r_hold_cnt  <= '0;
          r_long      <= 1'b0;
          r_repeating <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign step       = r_step;
  assign tap        = r_tap;
  assign long_press = r_long;
  assign repeating  = r_repeating;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_button_autorepeat.sv
// -----------------------------------------------------------------------------
// tb_button_autorepeat
//
// Directed scenarios for button_autorepeat, configured for 4 cycles per ms,
// HOLD_MS = 5, REPEAT_MS = 2 and LONG_MS = 12.
//
// The reference model works only from the time elapsed since the press edge.
// On every cycle it predicts step, tap, long_press and repeating. An event
// log records output edges relative to the press edge, and hand-computed
// offsets are checked against that log.
// -----------------------------------------------------------------------------
module tb_button_autorepeat;

  localparam int TC        = 4;   // cycles per ms for CLK_PER = 250000
  localparam int HOLD_MS   = 5;
  localparam int REPEAT_MS = 2;
  localparam int LONG_MS   = 12;
  localparam int HOLD_CY   = HOLD_MS * TC;    // 20
  localparam int REP_CY    = REPEAT_MS * TC;  // 8
  localparam int LONG_CY   = LONG_MS * TC;    // 48

  // ---------------------------------------------------------------------------
  // Clock and reset
  // ---------------------------------------------------------------------------
  logic       clk = 1'b0;
  logic       reset;
  logic       button_level;
  logic       step;
  logic       tap;
  logic       long_press;
  logic       repeating;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  button_autorepeat #(
    .CLK_PER      (250000),
    .HOLD_MS      (HOLD_MS),
    .REPEAT_MS    (REPEAT_MS),
    .LONG_MS      (LONG_MS),
    .ENABLE_REPEAT(1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .button_level(button_level),
    .step        (step),
    .tap         (tap),
    .long_press  (long_press),
    .repeating   (repeating),
    .dbg_state   (dbg_state)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------------------
  // Check bookkeeping
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_errors = 0;
  bit checking = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, $signed(act), $signed(exp), cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  //
  // t is the number of clock edges since the press edge.
  //   Press edge: one step.
  //   Steps while held: t = HOLD_CY, then every REP_CY after that.
  //   repeating: high while held once t >= HOLD_CY.
  //   long_press: high while held once t >= LONG_CY.
  //   Release at t: tap iff t <= HOLD_CY (a release on the expiry edge wins
  //   over the step), and all levels drop.
  // After reset the previous level counts as 1, so a held button needs a new
  // press.
  // ---------------------------------------------------------------------------
  logic m_step;
  logic m_tap;
  logic m_long;
  logic m_rep;
  logic m_active;
  logic m_prev;
  int   m_t;

  always @(posedge clk or posedge reset) begin : model
    int t_n;
    if (reset) begin
      m_step   <= 1'b0;
      m_tap    <= 1'b0;
      m_long   <= 1'b0;
      m_rep    <= 1'b0;
      m_active <= 1'b0;
      m_prev   <= 1'b1;
      m_t      <= 0;
    end else begin
      m_prev <= button_level;
      m_step <= 1'b0;
      m_tap  <= 1'b0;
      m_long <= 1'b0;
      m_rep  <= 1'b0;
      if (!m_active) begin
        if (button_level && !m_prev) begin
          m_active <= 1'b1;
          m_t      <= 0;
          m_step   <= 1'b1;
        end
      end else begin
        t_n = m_t + 1;
        m_t <= t_n;
        if (!button_level) begin
          m_active <= 1'b0;
          m_tap    <= (t_n <= HOLD_CY);
        end else begin
          m_step <= (t_n == HOLD_CY) || ((t_n > HOLD_CY) && (((t_n - HOLD_CY) % REP_CY) == 0));
          m_rep  <= (t_n >= HOLD_CY);
          m_long <= (t_n >= LONG_CY);
        end
      end
    end
  end

  // Compare process: outputs are checked on the falling edge, half a cycle
  // away from the edge that updates them.
  always @(negedge clk) begin
    if (checking) begin
      check("step", step, m_step);
      check("tap", tap, m_tap);
      check("long_press", long_press, m_long);
      check("repeating", repeating, m_rep);
    end
  end

  // ---------------------------------------------------------------------------
  // Event log, relative to the most recent press edge
  // ---------------------------------------------------------------------------
  int   press_edge = 0;
  int   step_offs[$];
  int   tap_offs[$];
  int   rep_rise;
  int   rep_fall;
  int   long_rise;
  int   long_fall;
  logic rep_prev = 1'b0;
  logic long_prev = 1'b0;

  always @(negedge clk) begin
    if (step === 1'b1) step_offs.push_back(cyc - press_edge);
    if (tap === 1'b1) tap_offs.push_back(cyc - press_edge);
    if (repeating === 1'b1 && !rep_prev) rep_rise = cyc - press_edge;
    if (repeating !== 1'b1 && rep_prev) rep_fall = cyc - press_edge;
    if (long_press === 1'b1 && !long_prev) long_rise = cyc - press_edge;
    if (long_press !== 1'b1 && long_prev) long_fall = cyc - press_edge;
    rep_prev  = (repeating === 1'b1);
    long_prev = (long_press === 1'b1);
  end

  // Scoreboard queue of expected step offsets.
  logic [7:0] exp_q[$];

  // ---------------------------------------------------------------------------
  // Driver tasks (inputs change on the falling edge)
  // ---------------------------------------------------------------------------
  task automatic clear_log();
    step_offs.delete();
    tap_offs.delete();
    rep_rise  = -1;
    rep_fall  = -1;
    long_rise = -1;
    long_fall = -1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press();
    @(negedge clk);
    button_level = 1'b1;
    press_edge   = cyc + 1;
  endtask

  // Release so that the edge numbered `edge_n` sees the low level.
  task automatic release_at(input int edge_n);
    while (cyc < edge_n - 1) @(negedge clk);
    button_level = 1'b0;
  endtask

  task automatic check_steps(input string name);
    logic [7:0] e;
    int a;
    check({name, "_count"}, step_offs.size(), exp_q.size());
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = (step_offs.size() > 0) ? step_offs.pop_front() : -1;
      check({name, "_offset"}, a, {24'd0, e});
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  initial begin
    button_level = 1'b0;
    reset        = 1'b1;
    clear_log();
    repeat (3) @(negedge clk);
    check("reset_step", step, 1'b0);
    check("reset_repeating", repeating, 1'b0);
    reset    = 1'b0;
    checking = 1'b1;

    // 1: idle after reset, nothing fires.
    clear_log();
    idle(100);
    check("t1_steps", step_offs.size(), 0);
    check("t1_taps", tap_offs.size(), 0);
    check("t1_rep_rise", rep_rise, -1);
    check("t1_long_rise", long_rise, -1);

    // 2: short press, released on edge +12 -> one step and one tap.
    clear_log();
    press();
    release_at(press_edge + 12);
    idle(10);
    exp_q = '{8'd0};
    check_steps("t2_steps");
    check("t2_tap_count", tap_offs.size(), 1);
    if (tap_offs.size() > 0) check("t2_tap_offset", tap_offs[0], 12);
    check("t2_rep_rise", rep_rise, -1);

    // 3: hold 40 cycles -> steps at 0, 20, 28, 36; repeating 20..39.
    clear_log();
    press();
    release_at(press_edge + 40);
    idle(10);
    exp_q = '{8'd0, 8'd20, 8'd28, 8'd36};
    check_steps("t3_steps");
    check("t3_rep_rise", rep_rise, 20);
    check("t3_rep_fall", rep_fall, 40);
    check("t3_taps", tap_offs.size(), 0);

    // 4: hold 52 cycles -> long_press over 48..51.
    clear_log();
    press();
    release_at(press_edge + 52);
    idle(10);
    exp_q = '{8'd0, 8'd20, 8'd28, 8'd36, 8'd44};
    check_steps("t4_steps");
    check("t4_long_rise", long_rise, 48);
    check("t4_long_fall", long_fall, 52);
    check("t4_taps", tap_offs.size(), 0);

    // 5: reset at cycle 25 of a hold, deassert while still held.
    clear_log();
    press();
    while (cyc < press_edge + 25) @(negedge clk);
    check("t5_rep_before_reset", repeating, 1'b1);
    #1 reset = 1'b1;
    #1;
    check("t5_reset_repeating", repeating, 1'b0);
    check("t5_reset_step", step, 1'b0);
    check("t5_reset_long", long_press, 1'b0);
    check("t5_reset_tap", tap, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    clear_log();
    idle(30);
    check("t5_held_steps", step_offs.size(), 0);
    check("t5_held_rep", rep_rise, -1);
    check("t5_held_taps", tap_offs.size(), 0);
    button_level = 1'b0;
    idle(5);
    clear_log();
    press();
    release_at(press_edge + 6);
    idle(8);
    exp_q = '{8'd0};
    check_steps("t5_repress_steps");
    check("t5_repress_tap_count", tap_offs.size(), 1);
    if (tap_offs.size() > 0) check("t5_repress_tap_offset", tap_offs[0], 6);

    // 6: release on the edge of the repeat step at 28 -> that step is dropped.
    clear_log();
    press();
    release_at(press_edge + 28);
    idle(10);
    exp_q = '{8'd0, 8'd20};
    check_steps("t6_steps");
    check("t6_taps", tap_offs.size(), 0);
    check("t6_rep_fall", rep_fall, 28);
    check("t6_state_idle", dbg_state, 2'd0);
    clear_log();
    press();
    release_at(press_edge + 4);
    idle(6);
    exp_q = '{8'd0};
    check_steps("t6_next_steps");
    check("t6_next_tap_count", tap_offs.size(), 1);
    if (tap_offs.size() > 0) check("t6_next_tap_offset", tap_offs[0], 4);

    checking = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
